// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier
//   Iterative unsigned multiplier, one shift-add step per clock.
//   Prod = A * B, exact, 2*WIDTH bits. Fixed latency of WIDTH clocks from
//   accept to out_valid; a zero operand still runs every iteration.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for in_valid; in_ready=1
//   BUSY  | running WIDTH shift-add iterations; request channel closed
//   DONE  | Prod valid and held until out_ready
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   requester has operands on A/B
//   in_ready   block can accept operands (registered)
//   A          multiplicand, unsigned, WIDTH bits
//   B          multiplier, unsigned, WIDTH bits
//   out_valid  Prod holds a completed result (registered)
//   out_ready  consumer takes the result
//   Prod       product, 2*WIDTH bits; keeps the last result after handoff
//   busy       high in BUSY or DONE (registered)
module seq_shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       A,
    input  logic [WIDTH-1:0]       B,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     Prod,
    output logic                   busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [WIDTH-1:0]     m_q,         m_d;
    logic [2*WIDTH:0]     p_q,         p_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic [2*WIDTH-1:0]   prod_q,      prod_d;
    logic                 in_ready_q,  in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q,      busy_d;

    logic [WIDTH:0]       upper;
    logic [2*WIDTH:0]     p_shifted;

    always_comb begin
        // Upper half is WIDTH+1 bits so the add carry is kept and then
        // shifted down into the product on the same step.
        if (p_q[0]) begin
            upper = p_q[2*WIDTH:WIDTH] + {1'b0, m_q};
        end else begin
            upper = p_q[2*WIDTH:WIDTH];
        end
        p_shifted = {1'b0, upper, p_q[WIDTH-1:1]};

        state_d = state_q;
        m_d     = m_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    m_d     = A;
                    p_d     = {{(WIDTH+1){1'b0}}, B};
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                p_d   = p_shifted;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    prod_d  = p_shifted[2*WIDTH-1:0];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake outputs are registered, derived from the next state.
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            m_q         <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign Prod      = prod_q;

endmodule
